flash_read: RTL and testbench



---
 rtl/flash_read.sv | 116 +++++++++++
 tb/tb_flash_read.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/flash_read.sv
// flash_read: burst reader for a 16-bit asynchronous NOR flash, one word per rd_valid strobe.
// Define FLASH_READ_ARRAY_CMD_EN to issue a read-array (0x00FF) command write before the first word.
module flash_read #(
  parameter int T_VLVH = 2,
  parameter int T_AVQV = 6,
  parameter int T_EHEL = 2
`ifdef FLASH_READ_ARRAY_CMD_EN
  , parameter int T_WLWH = 4,
  parameter int T_WHWL = 3
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_en,
  input  logic [24:0] read_addr,
  input  logic [15:0] read_len,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        read_done,
  output logic [24:0] A,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dqe,
  output logic        oe,
  output logic        ce,
  output logic        we,
  output logic        adv,
  output logic        wp,
  output logic        rst_f
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACC, S_CAP, S_GAP, S_DONE
`ifdef FLASH_READ_ARRAY_CMD_EN
    , S_CADV, S_CWE, S_CHLD, S_CREC
`endif
  } state_t;
`ifdef FLASH_READ_ARRAY_CMD_EN
  localparam state_t S_FIRST = S_CADV;
`else
  localparam state_t S_FIRST = S_ADDR;
`endif
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [24:0] r_addr;
  logic [15:0] r_rem;
  logic        r_rst_f;
  logic        w_cmd_a, w_cmd_ce, w_cmd_adv;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (read_en) w_next = (read_len == 16'd0) ? S_DONE : S_FIRST;
      S_ADDR: if (r_cnt == 8'(T_VLVH - 1)) w_next = S_ACC;
      S_ACC:  if (r_cnt == 8'(T_AVQV - 1)) w_next = S_CAP;
      S_CAP:  w_next = S_GAP;
      S_GAP:  if (r_cnt == 8'(T_EHEL - 1)) w_next = (r_rem != 16'd0) ? S_ADDR : S_DONE;
      S_DONE: w_next = S_IDLE;
`ifdef FLASH_READ_ARRAY_CMD_EN
      S_CADV: if (r_cnt == 8'(T_VLVH - 1)) w_next = S_CWE;
      S_CWE:  if (r_cnt == 8'(T_WLWH - 1)) w_next = S_CHLD;
      S_CHLD: w_next = S_CREC;
      S_CREC: if (r_cnt == 8'(T_WHWL - 1)) w_next = S_ADDR;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  // r_cnt counts cycles spent in the current state and restarts on every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rem    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      r_rst_f  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      rd_valid <= (r_state == S_CAP);
      r_rst_f  <= 1'b1;
      if (r_state == S_IDLE && read_en) begin
        r_addr <= read_addr;
        r_rem  <= read_len;
      end
      if (r_state == S_CAP) begin
        rd_data <= dq_i;
        r_rem   <= r_rem - 16'd1;
        r_addr  <= r_addr + 25'd1;
      end
    end
  end
`ifdef FLASH_READ_ARRAY_CMD_EN
  assign w_cmd_a   = (r_state == S_CADV) || (r_state == S_CWE) || (r_state == S_CHLD);
  assign w_cmd_ce  = (r_state == S_CADV) || (r_state == S_CWE);
  assign w_cmd_adv = (r_state == S_CADV);
  assign we        = (r_state != S_CWE);
  assign dqe       = (r_state == S_CWE) || (r_state == S_CHLD);
  assign dq_o      = dqe ? 16'h00FF : 16'h0000;
`else
  assign w_cmd_a   = 1'b0;
  assign w_cmd_ce  = 1'b0;
  assign w_cmd_adv = 1'b0;
  assign we        = 1'b1;
  assign dqe       = 1'b0;
  assign dq_o      = 16'h0000;
`endif
  assign A         = (r_state == S_ADDR || r_state == S_ACC || r_state == S_CAP || w_cmd_a) ? r_addr : 25'd0;
  assign ce        = !(r_state == S_ADDR || r_state == S_ACC || r_state == S_CAP || w_cmd_ce);
  assign adv       = !(r_state == S_ADDR || w_cmd_adv);
  assign oe        = !(r_state == S_ACC || r_state == S_CAP);
  assign wp        = 1'b1;
  assign rst_f     = r_rst_f;
  assign busy      = (r_state != S_IDLE);
  assign read_done = (r_state == S_DONE);
endmodule

// File: tb/tb_flash_read.sv
// tb_flash_read: directed vector table plus reset-mid-burst sequence for flash_read.
module tb_flash_read;
`ifdef FLASH_READ_ARRAY_CMD_EN
  localparam int CMD = 10;
  localparam int CMD_WL = 4;
  localparam int CMD_P = 1;
`else
  localparam int CMD = 0;
  localparam int CMD_WL = 0;
  localparam int CMD_P = 0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, read_en = 1'b0;
  logic [24:0] read_addr = '0;
  logic [15:0] read_len = '0;
  logic        busy, rd_valid, read_done, dqe, oe, ce, we, adv, wp, rst_f;
  logic [15:0] rd_data, dq_o, dq_i;
  logic [24:0] A;
  int n_run = 0, n_fail = 0;
  flash_read dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr), .read_len(read_len),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .read_done(read_done),
    .A(A), .dq_i(dq_i), .dq_o(dq_o), .dqe(dqe), .oe(oe), .ce(ce), .we(we), .adv(adv),
    .wp(wp), .rst_f(rst_f)
  );
  always #5 clk = ~clk;
  // flash model: every location reads back the low half of its address
  assign dq_i = A[15:0];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic run(input logic [24:0] a, input logic [15:0] n, input bit poke, input int exp_done);
    int nv = 0, nd = 0, dc = -1, wl = 0, wf = 0, lo = 0, dqbad = 0;
    logic prev_we = 1'b1;
    logic [24:0] la = '0;
    logic [24:0] e;
    @(negedge clk);
    read_addr = a;
    read_len = n;
    read_en = 1'b1;
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        read_en = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
      end
      if (poke && c == 30) begin
        read_en = 1'b1;
        read_addr = a + 25'h1000;
        read_len = 16'd9;
      end
      if (poke && c == 31) read_en = 1'b0;
      if (!oe) la = A;
      if (!oe || !ce) lo++;
      if (!we) begin
        wl++;
        if (dq_o !== 16'h00FF || dqe !== 1'b1) dqbad++;
      end
      if (prev_we && !we) wf++;
      prev_we = we;
      if (rd_valid) begin
        e = a + 25'(nv);
        chk("rd_data", 32'(rd_data), 32'(e[15:0]));
        chk("addr", 32'(la), 32'(e));
        chk("strobe_cyc", 32'(c), 32'(10 + CMD + 11 * nv));
        nv++;
      end
      if (read_done) begin
        nd++;
        dc = c;
      end
      if (dc > 0 && c == dc + 1) begin
        chk("busy_after", 32'(busy), 32'd0);
        break;
      end
    end
    chk("strobes", 32'(nv), 32'(n));
    chk("done_cyc", 32'(dc), 32'(exp_done + ((n != 0) ? CMD : 0)));
    chk("done_count", 32'(nd), 32'd1);
    chk("we_low_cyc", 32'(wl), 32'((n != 0) ? CMD_WL : 0));
    chk("we_pulses", 32'(wf), 32'((n != 0) ? CMD_P : 0));
    chk("dq_cmd", 32'(dqbad), 32'd0);
    if (n == 0) chk("no_bus", 32'(lo), 32'd0);
  endtask
  typedef struct {
    logic [24:0] addr;
    logic [15:0] len;
    bit          poke;
    int          done_cyc;
  } vec_t;
  vec_t vecs[5];
  initial begin
    int nd;
    vecs[0] = '{25'h0000100, 16'd4, 1'b0, 45};
    vecs[1] = '{25'h0000000, 16'd0, 1'b0, 1};
    vecs[2] = '{25'h1FFFFFE, 16'd3, 1'b0, 34};
    vecs[3] = '{25'h0000100, 16'd4, 1'b1, 45};
    vecs[4] = '{25'h00ABCDE, 16'd1, 1'b0, 12};
    #1;
    chk("rst_A", 32'(A), 32'd0);
    chk("rst_strobes", {27'd0, oe, ce, we, adv, wp}, 32'h1F);
    chk("rst_rst_f", 32'(rst_f), 32'd0);
    chk("rst_outs", {28'd0, rd_valid, read_done, busy, dqe}, 32'd0);
    chk("rst_dq", 32'(dq_o), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_f_up", 32'(rst_f), 32'd1);
    for (int i = 0; i < 5; i++) run(vecs[i].addr, vecs[i].len, vecs[i].poke, vecs[i].done_cyc);
    // reset during the access phase of the second word
    @(negedge clk);
    read_addr = 25'h0000200;
    read_len = 16'd4;
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    repeat (15 + CMD) @(negedge clk);
    chk("acc_oe", {30'd0, oe, ce}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {29'd0, oe, ce, adv}, 32'h7);
    chk("mid_rst_outs", {29'd0, rd_valid, read_done, busy}, 32'd0);
    chk("mid_rst_rst_f", 32'(rst_f), 32'd0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (read_done || rd_valid) nd++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (read_done || rd_valid) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'd0);
    run(25'h0000300, 16'd2, 1'b0, 23);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
